maxpool2x2_stream: RTL and testbench

//  Streaming 2x2/stride-2 signed max-pool stage, directly downstream of the ReLU stage in the CNN datapath.

---
 rtl/maxpool2x2_stream.sv | 143 ++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-ordered frame.
// Keeps half a row of horizontal maxima and emits one result per window.
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 26,
    parameter int IMG_HEIGHT = 26
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic signed [DATA_WIDTH-1:0] out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         done_o
);

    localparam int PW = IMG_WIDTH / 2;
    localparam int PH = IMG_HEIGHT / 2;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;
    localparam int NW = $clog2(PH * PW + 1);

    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic [NW-1:0]                ocnt_q, ocnt_d;
    logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic                         out_valid_q, out_valid_d;
    logic                         done_q, done_d;

    logic signed [DATA_WIDTH-1:0] rowbuf_q [PW];

    logic                         acc, drain;
    logic                         even_col, odd_col;
    logic                         wr_row, rd_row;
    logic                         buf_we, load;
    logic [IW-1:0]                idx;
    logic signed [DATA_WIDTH-1:0] hmax, rd, pmax;

    assign in_ready_o  = !start_i && !(out_valid_q && !out_ready_i);
    assign out_data_o  = out_q;
    assign out_valid_o = out_valid_q;
    assign done_o      = done_q;

    assign acc   = in_valid_i && in_ready_o;
    assign drain = out_valid_q && out_ready_i;
    assign idx   = IW'(col_q >> 1);

    // A trailing odd column or row never reaches the buffer or the output.
    assign even_col = !col_q[0] && (int'(col_q) < 2 * PW);
    assign odd_col  = col_q[0];
    assign wr_row   = !row_q[0] && (int'(row_q) < 2 * PH);
    assign rd_row   = row_q[0];

    assign hmax = (in_data_i > hold_q) ? in_data_i : hold_q;
    assign rd   = rowbuf_q[idx];
    assign pmax = (rd > hmax) ? rd : hmax;

    assign buf_we = acc && odd_col && wr_row;
    assign load   = acc && odd_col && rd_row;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        ocnt_d      = ocnt_q;
        hold_d      = hold_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        if (acc) begin
            if (col_q == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_HEIGHT - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            if (even_col) begin
                hold_d = in_data_i;
            end
        end

        if (drain) begin
            out_valid_d = 1'b0;
            if (ocnt_q == NW'(PH * PW - 1)) begin
                ocnt_d = '0;
                done_d = 1'b1;
            end else begin
                ocnt_d = ocnt_q + 1'b1;
            end
        end

        // A load in the drain cycle wins, so valid stays high.
        if (load) begin
            out_d       = pmax;
            out_valid_d = 1'b1;
        end

        if (start_i) begin
            col_d       = '0;
            row_d       = '0;
            ocnt_d      = '0;
            hold_d      = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            ocnt_q      <= '0;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ocnt_q      <= ocnt_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            rowbuf_q[idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 and a 5x5 instance share
// the input drive; only the selected instance's outputs are collected.
module tb_maxpool2x2_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, in_valid, out_ready;
    logic signed [31:0] in_data;
    logic               rdy4, rdy5, ov4, ov5, done4, done5;
    logic signed [31:0] od4, od5;

    maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .out_data_o(od4), .out_valid_o(ov4), .out_ready_i(out_ready),
        .done_o(done4)
    );

    maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(rdy5),
        .out_data_o(od5), .out_valid_o(ov5), .out_ready_i(out_ready),
        .done_o(done5)
    );

    typedef struct {
        int base;
        int step;
        int e0, e1, e2, e3;
    } vec_t;

    vec_t tbl [6];
    int   errors = 0;
    int   checks = 0;
    int   q [$];
    int   done_cnt = 0;
    bit   sel = 1'b0;

    always @(negedge clk) begin
        if (!sel) begin
            if (ov4 && out_ready) q.push_back(od4);
            if (done4) done_cnt++;
        end else begin
            if (ov5 && out_ready) q.push_back(od5);
            if (done5) done_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int i, input int exp);
        int act;
        act = (i < q.size()) ? q[i] : 32'h7fffffff;
        chk(nm, act, exp);
    endtask

    task automatic send(input int d);
        int  t;
        bit  acc;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            acc = sel ? rdy5 : rdy4;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 100);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input int base, input int step, input int n);
        for (int i = 0; i < n; i++) send(base + step * i);
    endtask

    task automatic begin_test(input bit s);
        sel = s;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_out(input string nm, input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_count"}, q.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{base:   0, step:  1, e0:   5, e1:   7, e2:  13, e3:  15};
        tbl[1] = '{base: -16, step:  1, e0: -11, e1:  -9, e2:  -3, e3:  -1};
        tbl[2] = '{base: 100, step:  1, e0: 105, e1: 107, e2: 113, e3: 115};
        tbl[3] = '{base:  15, step: -1, e0:  15, e1:  13, e2:   7, e3:   5};
        tbl[4] = '{base:  -1, step: -1, e0:  -1, e1:  -3, e2:  -9, e3: -11};
        tbl[5] = '{base:   7, step:  0, e0:   7, e1:   7, e2:   7, e3:   7};

        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", ov4, 0);
        chk("rst_data", od4, 0);
        chk("rst_done", done4, 0);
        chk("rst_ready", rdy4, 1);
        chk("rst_valid5", ov5, 0);

        for (int k = 0; k < 6; k++) begin
            begin_test(1'b0);
            send_frame(tbl[k].base, tbl[k].step, 16);
            in_valid = 1'b0;
            wait_out($sformatf("tbl%0d", k), 4);
            chk_q($sformatf("tbl%0d_o0", k), 0, tbl[k].e0);
            chk_q($sformatf("tbl%0d_o1", k), 1, tbl[k].e1);
            chk_q($sformatf("tbl%0d_o2", k), 2, tbl[k].e2);
            chk_q($sformatf("tbl%0d_o3", k), 3, tbl[k].e3);
            chk($sformatf("tbl%0d_done", k), done_cnt, 1);
        end

        begin_test(1'b0);
        fork
            begin
                send_frame(0, 1, 16);
                in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                @(posedge clk);
                #1;
                while (!ov4 && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                out_ready = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("stall_ready", rdy4, 0);
                    chk("stall_data", od4, 5);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_out("stall", 4);
        chk_q("stall_o0", 0, 5);
        chk_q("stall_o1", 1, 7);
        chk_q("stall_o2", 2, 13);
        chk_q("stall_o3", 3, 15);
        chk("stall_done", done_cnt, 1);

        begin_test(1'b1);
        send_frame(0, 1, 25);
        in_valid = 1'b0;
        wait_out("odd5", 4);
        chk_q("odd5_o0", 0, 6);
        chk_q("odd5_o1", 1, 8);
        chk_q("odd5_o2", 2, 16);
        chk_q("odd5_o3", 3, 18);
        chk("odd5_done", done_cnt, 1);

        for (int m = 0; m < 2; m++) begin
            begin_test(1'b0);
            out_ready = 1'b0;
            send_frame(0, 1, 6);
            in_valid = 1'b0;
            if (m == 0) rst = 1'b1;
            else        start = 1'b1;
            @(posedge clk);
            #1;
            rst       = 1'b0;
            start     = 1'b0;
            out_ready = 1'b1;
            send_frame(100, 1, 16);
            in_valid = 1'b0;
            wait_out($sformatf("abort%0d", m), 4);
            chk_q($sformatf("abort%0d_o0", m), 0, 105);
            chk_q($sformatf("abort%0d_o1", m), 1, 107);
            chk_q($sformatf("abort%0d_o2", m), 2, 113);
            chk_q($sformatf("abort%0d_o3", m), 3, 115);
            chk($sformatf("abort%0d_done", m), done_cnt, 1);
        end

        begin_test(1'b0);
        send_frame(0, 1, 16);
        send_frame(100, 1, 16);
        in_valid = 1'b0;
        wait_out("b2b", 8);
        chk_q("b2b_o0", 0, 5);
        chk_q("b2b_o1", 1, 7);
        chk_q("b2b_o2", 2, 13);
        chk_q("b2b_o3", 3, 15);
        chk_q("b2b_o4", 4, 105);
        chk_q("b2b_o5", 5, 107);
        chk_q("b2b_o6", 6, 113);
        chk_q("b2b_o7", 7, 115);
        chk("b2b_done", done_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
